ramp_soft_start_ctrl: RTL

RAMP_SOFT_START_CTRL -- requirements
Module: ramp_soft_start_ctrl

---
 rtl/ramp_pkg.sv | 32 +++
 rtl/ramp_soft_start_ctrl_tick_prescaler.sv | 40 ++++
 rtl/ramp_soft_start_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ramp_pkg.sv
// Shared types and duty thresholds for the soft-start ramp controller.
package ramp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP_UP,
        S_RUN,
        S_RAMP_DOWN
    } state_e;

    // Ramp rate latched when a ramp-up begins; ramp-down always runs fast.
    typedef enum logic {
        RATE_FAST,
        RATE_SLOW
    } rate_e;

    // Full-scale duty for a given PWM width.
    function automatic int dmax(input int bits);
        return (1 << bits) - 1;
    endfunction

    // 30 % of full scale, truncated.
    function automatic int th_30(input int bits);
        return (dmax(bits) * 3) / 10;
    endfunction

    // 50 % of full scale, truncated.
    function automatic int th_50(input int bits);
        return dmax(bits) / 2;
    endfunction

endpackage

// File: rtl/ramp_soft_start_ctrl_tick_prescaler.sv
// Divides clk down to a one-cycle tick every DIV enabled cycles.
module tick_prescaler #(
    parameter int DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next count: clear wins, otherwise count while enabled and wrap after the tick.
    always_comb begin
        // NOTE: default assigned first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ramp_soft_start_ctrl.sv
// Soft-start PWM duty ramp: fast/slow ramp up, fast ramp down, registered PWM and flags.
module ramp_soft_start_ctrl
    import ramp_pkg::*;
#(
    parameter int TICK_DIV   = 10_000_000,
    parameter int FAST_TICKS = 1,
    parameter int SLOW_TICKS = 3,
    parameter int PWM_BITS   = 8,
    parameter int DUTY_STEP  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                start_fast,
    input  logic                start_slow,
    input  logic                stop,
    output logic [PWM_BITS-1:0] duty,
    output logic                pwm,
    output logic                out_30,
    output logic                out_50,
    output logic                out_100,
    output logic                busy,
    output logic                at_speed
);

    localparam logic [PWM_BITS-1:0] DMAX     = PWM_BITS'(dmax(PWM_BITS));
    localparam logic [PWM_BITS-1:0] TH30     = PWM_BITS'(th_30(PWM_BITS));
    localparam logic [PWM_BITS-1:0] TH50     = PWM_BITS'(th_50(PWM_BITS));
    localparam logic [PWM_BITS-1:0] STEP_W   = PWM_BITS'(DUTY_STEP);
    localparam logic [PWM_BITS:0]   STEP_EXT = {1'b0, STEP_W};
    localparam logic [3:0]          FAST_R   = 4'(FAST_TICKS);
    localparam logic [3:0]          SLOW_R   = 4'(SLOW_TICKS);

    state_e              state_q, state_d;
    rate_e               rate_q, rate_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [3:0]          step_cnt_q, step_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pwm_q, out_30_q, out_50_q, out_100_q, busy_q, at_speed_q;

    logic                tick, step_evt, state_chg, pre_en, start_any;
    logic [3:0]          step_rate;
    logic [PWM_BITS:0]   duty_sum;
    logic [PWM_BITS-1:0] duty_up, duty_dn;

    // Prescaler only runs while a ramp is in progress.
    assign pre_en    = ena && ((state_q == S_RAMP_UP) || (state_q == S_RAMP_DOWN));
    assign state_chg = (state_d != state_q);
    assign start_any = start_fast || start_slow;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (state_chg),
        .tick  (tick)
    );

    // Ticks per duty step: ramp-down always fast, ramp-up uses the latched rate.
    assign step_rate = (state_q == S_RAMP_DOWN || rate_q == RATE_FAST) ? FAST_R : SLOW_R;
    assign step_evt  = tick && (step_cnt_q == step_rate - 4'd1);

    // Saturating duty arithmetic.
    assign duty_sum = {1'b0, duty_q} + STEP_EXT;
    assign duty_up  = (duty_sum >= {1'b0, DMAX}) ? DMAX : duty_sum[PWM_BITS-1:0];
    assign duty_dn  = ({1'b0, duty_q} > STEP_EXT) ? (duty_q - STEP_W) : '0;

    // Step counter: cleared on any state change, wraps after each step event.
    always_comb begin
        step_cnt_d = step_cnt_q;
        if (state_chg) begin
            step_cnt_d = '0;
        end else if (tick) begin
            step_cnt_d = step_evt ? 4'd0 : step_cnt_q + 4'd1;
        end
    end

    // FSM next state, latched rate and duty; everything holds while ena is low.
    always_comb begin
        state_d = state_q;
        rate_d  = rate_q;
        duty_d  = duty_q;
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    duty_d = '0;
                    if (!stop && start_any) begin
                        state_d = S_RAMP_UP;
                        rate_d  = start_slow ? RATE_SLOW : RATE_FAST;
                    end
                end
                S_RAMP_UP: begin
                    if (stop) begin
                        state_d = S_RAMP_DOWN;
                    end else if (step_evt) begin
                        duty_d = duty_up;
                        if (duty_up == DMAX) state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) state_d = S_RAMP_DOWN;
                end
                S_RAMP_DOWN: begin
                    if (!stop && start_any) begin
                        state_d = S_RAMP_UP;
                        rate_d  = start_slow ? RATE_SLOW : RATE_FAST;
                    end else if (step_evt) begin
                        duty_d = duty_dn;
                        if (duty_dn == '0) state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rate_q     <= RATE_FAST;
            duty_q     <= '0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rate_q     <= rate_d;
            duty_q     <= duty_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // PWM counter and registered outputs, each one cycle behind its cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q  <= '0;
            pwm_q      <= 1'b0;
            out_30_q   <= 1'b0;
            out_50_q   <= 1'b0;
            out_100_q  <= 1'b0;
            busy_q     <= 1'b0;
            at_speed_q <= 1'b0;
        end else begin
            if (ena) pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            pwm_q      <= (pwm_cnt_q < duty_q);
            out_30_q   <= (duty_q >= TH30);
            out_50_q   <= (duty_q >= TH50);
            out_100_q  <= (duty_q == DMAX);
            busy_q     <= (state_q == S_RAMP_UP) || (state_q == S_RAMP_DOWN);
            at_speed_q <= (state_q == S_RUN);
        end
    end

    assign duty     = duty_q;
    assign pwm      = pwm_q;
    assign out_30   = out_30_q;
    assign out_50   = out_50_q;
    assign out_100  = out_100_q;
    assign busy     = busy_q;
    assign at_speed = at_speed_q;

endmodule
